// File: rtl/page_table_walker_pkg.sv
// rtl/page_table_walker_pkg.sv - walker state encoding, PTE field positions and address helper
package page_table_walker_pkg;

  // Walker FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_L1    = 3'd1,
    ST_L2    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } ptw_state_e;

  // PTE bit positions, also used by the TLB for permission checks
  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 12;

  // Word-aligned PTE address from a 4K-aligned table base and a 10-bit index
  function automatic logic [31:0] pte_addr(input logic [19:0] base, input logic [9:0] idx);
    return {base, idx, 2'b00};
  endfunction

endpackage

// File: rtl/page_table_walker_pte_decode.sv
// rtl/page_table_walker_pte_decode.sv - combinational PTE classification
module page_table_walker_pte_decode
  import page_table_walker_pkg::*;
(
  input  logic [31:0] pte,
  output logic        is_pointer,
  output logic        is_leaf,
  output logic        is_invalid,
  output logic        superpage_misaligned
);

  logic v;
  logic r;
  logic w;
  logic x;
  logic unused_bits;

  assign v = pte[PTE_V];
  assign r = pte[PTE_R];
  assign w = pte[PTE_W];
  assign x = pte[PTE_X];

  // Invalid takes priority over leaf: a W-only PTE has V=1 and a permission bit set
  assign is_invalid           = !v || (w && !r);
  assign is_pointer           = v && !r && !w && !x;
  assign is_leaf              = v && (r || w || x);
  assign superpage_misaligned = |pte[PTE_PPN_LSB +: 10];

  // Upper PPN bits and the software field do not affect classification
  assign unused_bits = ^{pte[31:22], pte[11:4]};

endmodule

// File: rtl/page_table_walker.sv
// rtl/page_table_walker.sv - two-level page-table walker with timeout and flush handling
module page_table_walker
  import page_table_walker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ptbr,
  input  logic        flush_tlb,
  input  logic        walk_req,
  input  logic [31:0] walk_vaddr,
  output logic        walk_ready,
  output logic        walk_done,
  output logic [19:0] walk_ppn,
  output logic [2:0]  walk_perm,
  output logic        walk_fault,
  output logic        walk_timeout,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_rdata
);

  ptw_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [9:0]           vpn0_q, vpn0_d;
  logic                 ready_q, ready_d;
  logic                 mem_req_q, mem_req_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic                 done_q, done_d;
  logic [19:0]          ppn_q, ppn_d;
  logic [2:0]           perm_q, perm_d;
  logic                 fault_q, fault_d;
  logic                 timeout_q, timeout_d;

  logic                 pte_pointer;
  logic                 pte_leaf;
  logic                 pte_invalid;
  logic                 pte_misaligned;
  logic                 leaf_ok;
  logic                 unused_bits;

  page_table_walker_pte_decode u_pte_decode (
    .pte                  (mem_rdata),
    .is_pointer           (pte_pointer),
    .is_leaf              (pte_leaf),
    .is_invalid           (pte_invalid),
    .superpage_misaligned (pte_misaligned)
  );

  // Page offsets never take part in the walk
  assign unused_bits = ^{ptbr[11:0], walk_vaddr[11:0]};

  // Next-state, PTE request and result computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vpn0_d     = vpn0_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    ppn_d      = ppn_q;
    perm_d     = perm_q;
    fault_d    = fault_q;
    timeout_d  = timeout_q;
    leaf_ok    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The L1 address is formed here so ptbr is not needed after accept
        if (walk_req && !flush_tlb) begin
          state_d    = ST_L1;
          vpn0_d     = walk_vaddr[21:12];
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = pte_addr(ptbr[31:12], walk_vaddr[31:22]);
        end
      end

      ST_L1, ST_L2: begin
        if (mem_data_valid) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          leaf_ok   = !pte_invalid && pte_leaf && ((state_q == ST_L2) || !pte_misaligned);
          if (flush_tlb) begin
            state_d = ST_IDLE;
          end else if ((state_q == ST_L1) && !pte_invalid && pte_pointer) begin
            state_d    = ST_L2;
            mem_req_d  = 1'b1;
            mem_addr_d = pte_addr(mem_rdata[31:12], vpn0_q);
          end else begin
            state_d   = ST_RESP;
            done_d    = 1'b1;
            fault_d   = !leaf_ok;
            timeout_d = 1'b0;
            ppn_d     = '0;
            perm_d    = '0;
            if (leaf_ok) begin
              perm_d = {mem_rdata[PTE_X], mem_rdata[PTE_W], mem_rdata[PTE_R]};
              ppn_d  = (state_q == ST_L1) ? {mem_rdata[31:22], vpn0_q} : mem_rdata[31:12];
            end
          end
        end else if (flush_tlb) begin
          // The read is still owed by the arbiter; keep requesting until it lands
          state_d = ST_DRAIN;
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          fault_d   = 1'b1;
          timeout_d = 1'b1;
          ppn_d     = '0;
          perm_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        if (mem_data_valid) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      vpn0_q     <= '0;
      ready_q    <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      ppn_q      <= '0;
      perm_q     <= '0;
      fault_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vpn0_q     <= vpn0_d;
      ready_q    <= ready_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
      ppn_q      <= ppn_d;
      perm_q     <= perm_d;
      fault_q    <= fault_d;
      timeout_q  <= timeout_d;
    end
  end

  // A flush during the response cycle swallows the done pulse
  assign walk_done    = done_q && !flush_tlb;
  assign walk_ready   = ready_q;
  assign walk_ppn     = ppn_q;
  assign walk_perm    = perm_q;
  assign walk_fault   = fault_q;
  assign walk_timeout = timeout_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;

endmodule
